alu_seq_arbiter: RTL



---
 rtl/alu_seq_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_arbiter.sv
// Shares one single-cycle ALU between two requesters; shifts run as repeated 1-bit passes.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie (default: round-robin).
module alu_seq_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_res,
    output logic               rsp_v,
    output logic               rsp_c_out,
    output logic               rsp_zero,
    output logic [3:0]         alu_opselect,
    output logic [WIDTH-1:0]   alu_x,
    output logic [WIDTH-1:0]   alu_y,
    input  logic [WIDTH-1:0]   alu_res,
    input  logic               alu_v,
    input  logic               alu_c_out,
    input  logic               alu_zero
);
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_NOP = 4'b1111;
    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_res;
    logic               r_rsp_v;
    logic               r_rsp_c;
    logic               r_rsp_z;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_grant;
    logic               w_gid;
    logic               w_prio1;
    logic [3:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_last_pass;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_prio1 = 1'b0;
`else
    logic r_rr_ptr;

    // Round-robin pointer: the requester not granted last time wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr <= ~w_gid;
        end
    end

    assign w_prio1 = r_rr_ptr;
`endif

    // Grant is only offered in IDLE; rst_n gating keeps ready low while reset is held.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && (r_state == ST_IDLE)) begin
            w_grant0 = req0_valid && (!req1_valid || !w_prio1);
            w_grant1 = req1_valid && (!req0_valid || w_prio1);
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign w_grant     = w_grant0 | w_grant1;
    assign w_gid       = w_grant1;
    assign w_op        = w_gid ? req1_op    : req0_op;
    assign w_a         = w_gid ? req1_a     : req0_a;
    assign w_b         = w_gid ? req1_b     : req0_b;
    assign w_shamt     = w_gid ? req1_shamt : req0_shamt;
    assign w_is_shift  = (w_op == OP_SHL) || (w_op == OP_SHR);
    assign w_last_pass = (r_cnt == CNT_ONE);
    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_grant) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_is_shift) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_shamt != {SHAMT_W{1'b0}}) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_EXEC:  w_state_nxt = ST_RESP;
            ST_SHIFT: w_state_nxt = w_last_pass ? ST_RESP : ST_SHIFT;
            ST_RESP:  w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU is only driven while an op is executing; otherwise a parked NOP with zero operands.
    always_comb begin
        alu_opselect = OP_NOP;
        alu_x        = {WIDTH{1'b0}};
        alu_y        = {WIDTH{1'b0}};
        if ((r_state == ST_EXEC) || (r_state == ST_SHIFT)) begin
            alu_opselect = r_op;
            alu_x        = r_acc;
            alu_y        = r_b;
        end else begin
            alu_opselect = OP_NOP;
            alu_x        = {WIDTH{1'b0}};
            alu_y        = {WIDTH{1'b0}};
        end
    end

    // Operand capture on grant; r_acc doubles as the shift accumulator fed back to x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_NOP;
            r_acc <= {WIDTH{1'b0}};
            r_b   <= {WIDTH{1'b0}};
            r_cnt <= {SHAMT_W{1'b0}};
            r_id  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_op  <= w_op;
                        r_acc <= w_a;
                        r_b   <= w_b;
                        r_cnt <= w_shamt;
                        r_id  <= w_gid;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= alu_res;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Response register: loaded from the final ALU pass (or directly for a zero-length shift).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_res   <= {WIDTH{1'b0}};
            r_rsp_v     <= 1'b0;
            r_rsp_c     <= 1'b0;
            r_rsp_z     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant && w_is_shift && (w_shamt == {SHAMT_W{1'b0}})) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_gid;
                        r_rsp_res   <= w_a;
                        r_rsp_v     <= 1'b0;
                        r_rsp_c     <= 1'b0;
                        r_rsp_z     <= (w_a == {WIDTH{1'b0}});
                    end
                end
                ST_EXEC, ST_SHIFT: begin
                    if ((r_state == ST_EXEC) || w_last_pass) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_res   <= alu_res;
                        r_rsp_v     <= alu_v;
                        r_rsp_c     <= alu_c_out;
                        r_rsp_z     <= alu_zero;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_v     = r_rsp_v;
    assign rsp_c_out = r_rsp_c;
    assign rsp_zero  = r_rsp_z;

endmodule
